// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM encoding, PC step and default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_stage_pkg;

    localparam int FE_PC_WIDTH_DEF = 16;
    localparam int FE_IR_WIDTH_DEF = 32;

    // Byte distance between consecutive instruction words.
    localparam int FE_PC_INC = 4;

    // RUN fetches sequentially; BR_WAIT idles until writeback resolves a branch.
    typedef enum logic [0:0] {
        FE_RUN     = 1'b0,
        FE_BR_WAIT = 1'b1
    } fe_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch <-> imem/decode/writeback bundle; master is the fetch stage, slave is its environment.
// Latency: n/a (wires only).
// Backpressure: stall inputs travel from decode to fetch; fetch answers by freezing O_*.
interface fetch_stage_if
    import fetch_stage_pkg::*;
#(
    parameter int PC_WIDTH = FE_PC_WIDTH_DEF,
    parameter int IR_WIDTH = FE_IR_WIDTH_DEF
);

    logic [IR_WIDTH-1:0] I_IMemData;
    logic                I_DepStallSignal;
    logic                I_GPUStallSignal;
    logic                I_BranchStallSignal;
    logic [PC_WIDTH-1:0] I_WriteBackPC;
    logic                I_WriteBackPCEn;
    logic [PC_WIDTH-3:0] O_IMemAddr;
    logic                O_IMemRdEn;
    logic [PC_WIDTH-1:0] O_PC;
    logic [IR_WIDTH-1:0] O_IR;
    logic                O_FE_Valid;
    logic                O_BrWait;

    modport master (
        input  I_IMemData,
        input  I_DepStallSignal,
        input  I_GPUStallSignal,
        input  I_BranchStallSignal,
        input  I_WriteBackPC,
        input  I_WriteBackPCEn,
        output O_IMemAddr,
        output O_IMemRdEn,
        output O_PC,
        output O_IR,
        output O_FE_Valid,
        output O_BrWait
    );

    modport slave (
        output I_IMemData,
        output I_DepStallSignal,
        output I_GPUStallSignal,
        output I_BranchStallSignal,
        output I_WriteBackPC,
        output I_WriteBackPCEn,
        input  O_IMemAddr,
        input  O_IMemRdEn,
        input  O_PC,
        input  O_IR,
        input  O_FE_Valid,
        input  O_BrWait
    );

endinterface

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register catching the imem word that lands while decode is stalled.
// Latency: captured value visible the cycle after load.
// Backpressure: none of its own; flush beats load beats drain.
module fetch_hold_buffer #(
    parameter int PC_WIDTH = 16,
    parameter int IR_WIDTH = 32
) (
    input  logic                core_clk,
    input  logic                arst_n,
    input  logic                load,
    input  logic                drain,
    input  logic                flush,
    input  logic [PC_WIDTH-1:0] in_pc,
    input  logic [IR_WIDTH-1:0] in_ir,
    output logic                valid,
    output logic [PC_WIDTH-1:0] out_pc,
    output logic [IR_WIDTH-1:0] out_ir
);

    logic                valid_q, valid_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;

    // Next entry: a squash discards everything, otherwise capture or release.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            pc_d    = in_pc;
            ir_d    = in_ir;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    assign valid  = valid_q;
    assign out_pc = pc_q;
    assign out_ir = ir_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues one imem read per cycle and presents PC/IR to decode.
// Latency: issue to O_FE_Valid is 2 cycles; redirect to first valid is 3 cycles.
// Backpressure: dep/GPU stall freezes O_* and stops issue; the in-flight word parks in the hold buffer.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int                  PC_WIDTH = FE_PC_WIDTH_DEF,
    parameter int                  IR_WIDTH = FE_IR_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] START_PC = '0
) (
    input logic           I_CLOCK,
    input logic           I_RESET_N,
    fetch_stage_if.master bus
);

    fe_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                req_v_q, req_v_d;
    logic [PC_WIDTH-1:0] o_pc_q, o_pc_d;
    logic [IR_WIDTH-1:0] o_ir_q, o_ir_d;
    logic                o_vld_q, o_vld_d;

    logic                stall;
    logic                accept;
    logic                br_take;
    logic                redirect;
    logic                issue;

    logic                hold_v;
    logic [PC_WIDTH-1:0] hold_pc;
    logic [IR_WIDTH-1:0] hold_ir;
    logic                hold_load;
    logic                hold_drain;
    logic                hold_flush;

    // Redirect targets are word-aligned; the byte offset bits carry no meaning.
    logic [1:0] unused_wb_lsbs;
    assign unused_wb_lsbs = bus.I_WriteBackPC[1:0];

    // Handshake terms. Issue is held off while reset is asserted so the read
    // strobe is quiet during reset even though the state already reads RUN.
    always_comb begin
        stall    = bus.I_DepStallSignal | bus.I_GPUStallSignal;
        accept   = o_vld_q & ~stall;
        br_take  = accept & bus.I_BranchStallSignal;
        redirect = bus.I_WriteBackPCEn;
        issue    = I_RESET_N & (state_q == FE_RUN) & ~stall & ~br_take & ~redirect;
    end

    // Next PC, request tag, output registers, hold-buffer control and FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        req_v_d    = issue;
        o_pc_d     = o_pc_q;
        o_ir_d     = o_ir_q;
        o_vld_d    = o_vld_q;
        hold_load  = 1'b0;
        hold_drain = 1'b0;
        hold_flush = 1'b0;

        if (issue) begin
            pc_d     = pc_q + PC_WIDTH'(FE_PC_INC);
            req_pc_d = pc_q;
        end

        if (redirect) begin
            // The response landing now belongs to the old path: never used.
            pc_d       = {bus.I_WriteBackPC[PC_WIDTH-1:2], 2'b00};
            hold_flush = 1'b1;
            o_vld_d    = 1'b0;
            state_d    = FE_RUN;
        end else if (br_take) begin
            hold_flush = 1'b1;
            o_vld_d    = 1'b0;
            state_d    = FE_BR_WAIT;
        end else if (state_q == FE_BR_WAIT) begin
            o_vld_d = 1'b0;
        end else if (stall) begin
            // No issue happens during a stall, so at most one word can arrive
            // before the buffer is drained again.
            hold_load = req_v_q;
        end else if (hold_v) begin
            o_pc_d     = hold_pc;
            o_ir_d     = hold_ir;
            o_vld_d    = 1'b1;
            hold_drain = 1'b1;
        end else begin
            o_pc_d  = req_pc_q;
            o_ir_d  = bus.I_IMemData;
            o_vld_d = req_v_q;
        end
    end

    // Stage state; reset discards in-flight work and restarts at START_PC.
    always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q  <= FE_RUN;
            pc_q     <= START_PC;
            req_pc_q <= '0;
            req_v_q  <= 1'b0;
            o_pc_q   <= '0;
            o_ir_q   <= '0;
            o_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_v_q  <= req_v_d;
            o_pc_q   <= o_pc_d;
            o_ir_q   <= o_ir_d;
            o_vld_q  <= o_vld_d;
        end
    end

    fetch_hold_buffer #(
        .PC_WIDTH (PC_WIDTH),
        .IR_WIDTH (IR_WIDTH)
    ) u_hold (
        .core_clk (I_CLOCK),
        .arst_n   (I_RESET_N),
        .load     (hold_load),
        .drain    (hold_drain),
        .flush    (hold_flush),
        .in_pc    (req_pc_q),
        .in_ir    (bus.I_IMemData),
        .valid    (hold_v),
        .out_pc   (hold_pc),
        .out_ir   (hold_ir)
    );

    assign bus.O_IMemAddr = pc_q[PC_WIDTH-1:2];
    assign bus.O_IMemRdEn = issue;
    assign bus.O_PC       = o_pc_q;
    assign bus.O_IR       = o_ir_q;
    assign bus.O_FE_Valid = o_vld_q;
    assign bus.O_BrWait   = (state_q == FE_BR_WAIT);

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam int PW = 16;
    localparam int IW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if #(.PC_WIDTH(PW), .IR_WIDTH(IW)) bus   ();
    fetch_stage_if #(.PC_WIDTH(PW), .IR_WIDTH(IW)) bus_w ();

    fetch_stage #(.PC_WIDTH(PW), .IR_WIDTH(IW), .START_PC(16'h0000)) dut (
        .I_CLOCK   (clk),
        .I_RESET_N (rst_n),
        .bus       (bus.master)
    );

    fetch_stage #(.PC_WIDTH(PW), .IR_WIDTH(IW), .START_PC(16'hFFF8)) dut_w (
        .I_CLOCK   (clk),
        .I_RESET_N (rst_n),
        .bus       (bus_w.master)
    );

    // Instruction memory content: tag | word address.
    function automatic logic [31:0] mem_word(input logic [15:0] pc);
        return 32'h1000_0000 | {18'd0, pc[15:2]};
    endfunction

    // Synchronous read, one cycle latency; junk on the bus when no read was issued.
    always @(posedge clk) begin
        if (bus.O_IMemRdEn) bus.I_IMemData <= 32'h1000_0000 | {18'd0, bus.O_IMemAddr};
        else                bus.I_IMemData <= $urandom;
    end
    always @(posedge clk) begin
        if (bus_w.O_IMemRdEn) bus_w.I_IMemData <= 32'h1000_0000 | {18'd0, bus_w.O_IMemAddr};
        else                  bus_w.I_IMemData <= $urandom;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        dep;
        logic        gpu;
        logic        br;
        logic        wb;
        logic [15:0] wbpc;
        logic        e_vld;
        logic [15:0] e_pc;
        logic        e_rd;
        logic [13:0] e_addr;
        logic        e_bw;
    } vec_t;

    function automatic vec_t mk(input logic dep, input logic gpu, input logic br, input logic wb,
                                input logic [15:0] wbpc, input logic ev, input logic [15:0] epc,
                                input logic erd, input logic [13:0] ea, input logic ebw);
        vec_t v;
        v.dep = dep; v.gpu = gpu; v.br = br; v.wb = wb; v.wbpc = wbpc;
        v.e_vld = ev; v.e_pc = epc; v.e_rd = erd; v.e_addr = ea; v.e_bw = ebw;
        return v;
    endfunction

    vec_t        vt [30];
    logic [15:0] wp;
    logic        r_dep, r_gpu, r_br, r_wb;
    logic [15:0] r_wbpc;
    logic [15:0] exp_pc;
    logic        m_bw;
    int          gap;

    task automatic drive(input logic dep, input logic gpu, input logic br, input logic wb,
                         input logic [15:0] wbpc);
        bus.I_DepStallSignal    = dep;
        bus.I_GPUStallSignal    = gpu;
        bus.I_BranchStallSignal = br;
        bus.I_WriteBackPCEn     = wb;
        bus.I_WriteBackPC       = wbpc;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          dep gpu br wb wbpc     | vld pc       rd addr    bw
        vt[0]  = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h000, 0);
        vt[1]  = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h001, 0);
        vt[2]  = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0000, 1, 14'h002, 0);
        vt[3]  = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0004, 1, 14'h003, 0);
        vt[4]  = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0008, 0, 14'h000, 0);
        vt[5]  = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0008, 0, 14'h000, 0);
        vt[6]  = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0008, 0, 14'h000, 0);
        vt[7]  = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0008, 1, 14'h004, 0);
        vt[8]  = mk(0, 0, 0, 0, 16'h0000,  1, 16'h000C, 1, 14'h005, 0);
        vt[9]  = mk(0, 1, 1, 0, 16'h0000,  1, 16'h0010, 0, 14'h000, 0);
        vt[10] = mk(0, 1, 1, 0, 16'h0000,  1, 16'h0010, 0, 14'h000, 0);
        vt[11] = mk(0, 0, 1, 0, 16'h0000,  1, 16'h0010, 0, 14'h000, 0);
        vt[12] = mk(1, 0, 0, 0, 16'h0000,  0, 16'h0000, 0, 14'h000, 1);
        vt[13] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 0, 14'h000, 1);
        vt[14] = mk(0, 0, 0, 1, 16'h0043,  0, 16'h0000, 0, 14'h000, 1);
        vt[15] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h010, 0);
        vt[16] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h011, 0);
        vt[17] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0040, 1, 14'h012, 0);
        vt[18] = mk(0, 0, 1, 1, 16'h0080,  1, 16'h0044, 0, 14'h000, 0);
        vt[19] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h020, 0);
        vt[20] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h021, 0);
        vt[21] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0080, 1, 14'h022, 0);
        vt[22] = mk(1, 0, 0, 1, 16'h0010,  1, 16'h0084, 0, 14'h000, 0);
        vt[23] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h004, 0);
        vt[24] = mk(0, 0, 0, 0, 16'h0000,  0, 16'h0000, 1, 14'h005, 0);
        vt[25] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0010, 1, 14'h006, 0);
        vt[26] = mk(1, 0, 0, 0, 16'h0000,  1, 16'h0014, 0, 14'h000, 0);
        vt[27] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0014, 1, 14'h007, 0);
        vt[28] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h0018, 1, 14'h008, 0);
        vt[29] = mk(0, 0, 0, 0, 16'h0000,  1, 16'h001C, 1, 14'h009, 0);

        drive(0, 0, 0, 0, 16'h0000);
        bus_w.I_DepStallSignal    = 1'b0;
        bus_w.I_GPUStallSignal    = 1'b0;
        bus_w.I_BranchStallSignal = 1'b0;
        bus_w.I_WriteBackPCEn     = 1'b0;
        bus_w.I_WriteBackPC       = 16'h0000;

        // Reset state.
        repeat (2) next_cycle();
        chk("rst_vld",   32'(bus.O_FE_Valid), 32'd0);
        chk("rst_pc",    32'(bus.O_PC),       32'd0);
        chk("rst_ir",    bus.O_IR,            32'd0);
        chk("rst_rden",  32'(bus.O_IMemRdEn), 32'd0);
        chk("rst_bw",    32'(bus.O_BrWait),   32'd0);
        chk("rst_addr",  32'(bus.O_IMemAddr), 32'd0);
        chk("rst_waddr", 32'(bus_w.O_IMemAddr), 32'h3FFE);

        // Directed cycle table from reset release; also watches the wrap DUT.
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            drive(vt[c].dep, vt[c].gpu, vt[c].br, vt[c].wb, vt[c].wbpc);
            @(negedge clk);
            chk($sformatf("c%0d_vld", c), 32'(bus.O_FE_Valid), 32'(vt[c].e_vld));
            if (vt[c].e_vld) begin
                chk($sformatf("c%0d_pc", c), 32'(bus.O_PC), 32'(vt[c].e_pc));
                chk($sformatf("c%0d_ir", c), bus.O_IR, mem_word(vt[c].e_pc));
            end
            chk($sformatf("c%0d_rden", c), 32'(bus.O_IMemRdEn), 32'(vt[c].e_rd));
            if (vt[c].e_rd)
                chk($sformatf("c%0d_addr", c), 32'(bus.O_IMemAddr), 32'(vt[c].e_addr));
            chk($sformatf("c%0d_bw", c), 32'(bus.O_BrWait), 32'(vt[c].e_bw));
            if (c >= 2 && c <= 5) begin
                wp = 16'hFFF8 + 16'(4 * (c - 2));
                chk($sformatf("wrap%0d_vld", c), 32'(bus_w.O_FE_Valid), 32'd1);
                chk($sformatf("wrap%0d_pc", c),  32'(bus_w.O_PC),       32'(wp));
                chk($sformatf("wrap%0d_ir", c),  bus_w.O_IR,            mem_word(wp));
            end
            next_cycle();
        end

        // Enter BR_WAIT, then drop reset asynchronously in the middle of a cycle.
        drive(0, 0, 1, 0, 16'h0000);
        @(negedge clk);
        chk("br30_pc", 32'(bus.O_PC), 32'h0020);
        next_cycle();
        drive(0, 0, 0, 0, 16'h0000);
        @(negedge clk);
        chk("br31_bw",  32'(bus.O_BrWait),   32'd1);
        chk("br31_vld", 32'(bus.O_FE_Valid), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_bw",   32'(bus.O_BrWait),   32'd0);
        chk("arst_vld",  32'(bus.O_FE_Valid), 32'd0);
        chk("arst_pc",   32'(bus.O_PC),       32'd0);
        chk("arst_ir",   bus.O_IR,            32'd0);
        chk("arst_rden", 32'(bus.O_IMemRdEn), 32'd0);
        chk("arst_addr", 32'(bus.O_IMemAddr), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel0_rden", 32'(bus.O_IMemRdEn), 32'd1);
        chk("rel0_addr", 32'(bus.O_IMemAddr), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rel1_vld", 32'(bus.O_FE_Valid), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rel2_vld", 32'(bus.O_FE_Valid), 32'd1);
        chk("rel2_pc",  32'(bus.O_PC),       32'd0);
        chk("rel2_ir",  bus.O_IR,            mem_word(16'h0000));

        // Random traffic against a program-order stream model.
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n  = 1'b1;
        exp_pc = 16'h0000;
        m_bw   = 1'b0;
        gap    = 0;
        for (int i = 0; i < 3000; i++) begin
            r_dep  = ($urandom_range(0, 4) == 0);
            r_gpu  = ($urandom_range(0, 7) == 0);
            r_br   = ($urandom_range(0, 5) == 0);
            r_wb   = m_bw ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            r_wbpc = 16'($urandom);
            drive(r_dep, r_gpu, r_br, r_wb, r_wbpc);
            @(negedge clk);
            chk("rnd_bw", 32'(bus.O_BrWait), 32'(m_bw));
            if (m_bw) chk("rnd_bw_vld", 32'(bus.O_FE_Valid), 32'd0);
            if (m_bw || r_dep || r_gpu || r_wb) chk("rnd_rden", 32'(bus.O_IMemRdEn), 32'd0);
            if (bus.O_FE_Valid) begin
                chk("rnd_pc", 32'(bus.O_PC), 32'(exp_pc));
                chk("rnd_ir", bus.O_IR, mem_word(exp_pc));
            end
            if (bus.O_FE_Valid || m_bw) gap = 0;
            else if (!(r_dep || r_gpu)) gap++;
            chk("rnd_gap", 32'(gap > 4), 32'd0);
            if (bus.O_FE_Valid && !(r_dep || r_gpu)) begin
                exp_pc = exp_pc + 16'd4;
                if (r_br) m_bw = 1'b1;
            end
            if (r_wb) begin
                m_bw   = 1'b0;
                exp_pc = {r_wbpc[15:2], 2'b00};
                gap    = 0;
            end
            next_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Front-end pipeline stage that produces the `I_PC` / `I_IR` / `I_FE_Valid` stream consumed by the decode stage. It also honours the decode stage's dependency, GPU and branch stall signals and redirects on the writeback branch target. The stage owns the program counter, drives a synchronous instruction-memory read port with a one-cycle latency, and absorbs that latency with a one-entry hold buffer so no instruction is lost or duplicated across stalls.

## Interface
- `PC_WIDTH`, default 16: PC width, byte address.
- `IR_WIDTH`, default 32: instruction width.
- `START_PC`, default 0: PC loaded at reset. Must be word-aligned.
- `I_CLOCK` in 1: single clock. All state updates on posedge.
- `I_RESET_N` in 1: asynchronous, active-low reset.
- `I_IMemData` in IR_WIDTH: instruction word for the address issued in the previous cycle.
- `I_DepStallSignal` in 1: decode cannot accept the current instruction (data dependency).
- `I_GPUStallSignal` in 1: downstream GPU stall; same effect as a dependency stall.
- `I_BranchStallSignal` in 1: the instruction on `O_IR` is a branch, `JMP`, `JSR` or `JSRR`.
- `I_WriteBackPC` in PC_WIDTH: resolved next PC.
- `I_WriteBackPCEn` in 1: redirect strobe, 1 cycle.
- `O_IMemAddr` out PC_WIDTH-2: word address, equal to `pc_q[PC_WIDTH-1:2]`.
- `O_IMemRdEn` out 1: read issue this cycle.
- `O_PC` out PC_WIDTH: PC of `O_IR`.
- `O_IR` out IR_WIDTH: fetched instruction.
- `O_FE_Valid` out 1: `O_PC` / `O_IR` hold a real instruction.
- `O_BrWait` out 1: FSM is in BR_WAIT.

## Operation
**State**
- `pc_q`: next PC to issue.
- Request tag `req_pc_q` / `req_v_q`: at most one read outstanding.
- Hold buffer: `hold_v` / `hold_pc` / `hold_ir`.
- Output registers: `O_PC`, `O_IR`, `O_FE_Valid`.
- FSM: RUN, BR_WAIT.

**Derived signals**
- `stall = I_DepStallSignal | I_GPUStallSignal`.
- `accept = O_FE_Valid & ~stall`.
- `br_take = accept & I_BranchStallSignal`.
- `issue = RUN & ~stall & ~br_take & ~I_WriteBackPCEn`.
  - `O_IMemRdEn = issue`.
  - On issue: `pc_q <= pc_q + 4` (wraps mod 2^PC_WIDTH); `req_pc_q <= pc_q`; `req_v_q <= 1`. Otherwise `req_v_q <= 0`.

**Per-cycle behaviour, in priority order**
1. **Redirect** (`I_WriteBackPCEn`, in either state):
   - `pc_q <= {I_WriteBackPC[PC_WIDTH-1:2], 2'b00}`.
   - Squash the outstanding response and the hold buffer.
   - `O_FE_Valid <= 0`; state becomes RUN.
2. **Branch taken** (`br_take`):
   - Outstanding response and hold buffer squashed.
   - `O_FE_Valid <= 0`; state becomes BR_WAIT.
   - No issue until redirect.
3. **Stall**:
   - `O_*` held.
   - A response arriving this cycle (`req_v_q`) is written to the hold buffer.
4. **Advance** (RUN, no stall):
   - If `hold_v`: `O_* <= hold_*` and the hold buffer is cleared.
   - Else: `O_PC <= req_pc_q`, `O_IR <= I_IMemData`, `O_FE_Valid <= req_v_q`.

**BR_WAIT**
- `O_FE_Valid` stays 0 and nothing is issued.
- Stalls are ignored.
- Leaves only on `I_WriteBackPCEn`.

**Invariants**
- The hold buffer can never be written while full, because there is no issue during a stall.
- At most one request is outstanding plus one instruction held.

**Boundary cases**
- Stall and branch together: the branch is not taken until the stall drops. Its `O_*` values are held meanwhile.
- Redirect in the same cycle as stall or `br_take`: redirect wins.
- `I_WriteBackPC[1:0]` is ignored.

## Timing
**Reset values** (asynchronous on `I_RESET_N` low):
- `pc_q = START_PC`; `O_PC = 0`; `O_IR = 0`; `O_FE_Valid = 0`; `O_IMemRdEn = 0`; `O_BrWait = 0`.
- `req_v_q = 0`; `hold_v = 0`; state RUN.
- Asserting reset mid-operation discards everything.

**Latencies**
- Cycle 0 is the first cycle after reset release. In cycle 0 the stage issues `START_PC`; `O_FE_Valid = 1` with `O_PC = START_PC` in cycle 2.
- Steady state: one instruction per cycle.
- Stall released at the end of cycle s: the held or buffered instruction appears in cycle s+1 with no bubble; the next sequential instruction appears in s+2.
- Redirect in cycle t: issue at the target in t+1; `O_FE_Valid = 1` in t+3.
- `br_take` in cycle t: `O_FE_Valid = 0` from t+1 until the redirect latency completes.

## Structure
- Shared header `global_def.h` already holds `PC_WIDTH`, `IR_WIDTH` and the opcodes.
- Add to it:
  - FSM encodings `FE_RUN` and `FE_BR_WAIT`.
  - `FE_PC_INC` = 4.
- One sub-module, `fetch_hold_buffer`: one-entry skid register.
  - Ports: `load`, `drain`, `flush`, `{pc, ir}`, `valid`.
  - Asynchronous active-low reset.
- The FSM and PC logic stay in `fetch_stage`.

## Test plan
1. **Sequential fetch.** Memory model returns `32'h1000_0000 | word_addr`; release reset → `O_FE_Valid` rises in cycle 2 with `O_PC` = 0, then `O_PC` = 4, 8, 12 on consecutive cycles and matching `O_IR`.
2. **Dependency stall.** Hold `I_DepStallSignal` for 3 cycles while `O_PC` = 8 → `O_PC` / `O_IR` held at 8 and `O_IMemRdEn` = 0 for those 3 cycles; after release, `O_PC` = 12 then 16 with no gap or duplicate. Repeat with `I_GPUStallSignal`.
3. **Branch and redirect.** `I_BranchStallSignal` at `O_PC` = 16 → `O_FE_Valid` = 0 next cycle, PC 20 never valid, `O_BrWait` = 1. Then `I_WriteBackPCEn` with `I_WriteBackPC` = 0x43 in cycle t → `O_PC` = 0x40 valid in t+3, then 0x44.
4. **Branch during stall.** Branch and dependency stall both asserted for 2 cycles → no BR_WAIT while stalled and the branch is held on `O_*`; BR_WAIT is entered the cycle after the stall drops.
5. **Reset mid-BR_WAIT.** Assert `I_RESET_N` = 0 during BR_WAIT → all outputs go to their reset values immediately; after release, fetch restarts at `START_PC`.
6. **Wrap-around.** `START_PC` = 0xFFF8, PC_WIDTH 16 → `O_PC` sequence 0xFFF8, 0xFFFC, 0x0000, 0x0004.
